// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR generator and its checker.
// Holds the FSM state encoding, LFSR/counter widths, the default seed and
// the 8-bit next-state function (full 256-state cycle, 8'h00 included).
package lfsr_pkg;

  localparam int unsigned LFSR_W     = 8;
  localparam int unsigned CLEAN_W    = 8;
  localparam int unsigned BURST_W    = 3;
  localparam int unsigned WORD_CNT_W = 16;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_INJECT = 2'd2
  } lfsr_state_e;

  // Maximal-length Galois step with the all-zero state spliced into the
  // cycle: the feedback bit is inverted whenever x[6:0] is zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    logic              fb;
    logic [LFSR_W-1:0] n;
    fb   = x[7] ^ (x[6:0] == 7'd0);
    n[0] = fb;
    n[1] = x[0];
    n[2] = x[1] ^ fb;
    n[3] = x[2] ^ fb;
    n[4] = x[3];
    n[5] = x[4];
    n[6] = x[5];
    n[7] = x[6] ^ fb;
    return n;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational LFSR next-state, shared with the stream checker.
// Ports:
//   i_state    current LFSR state
//   o_next_c   next LFSR state (combinational)
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] i_state,
  output logic [LFSR_W-1:0] o_next_c
);

  assign o_next_c = lfsr_next(i_state);

endmodule

// File: rtl/lfsr_generator.sv
// lfsr_generator: emits one LFSR word per enabled cycle and periodically
// replaces short bursts of words with a masked (corrupted) copy so that a
// downstream checker's error detection can be exercised.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_enable            emit a word this cycle; low stalls everything
//   i_load_seed/i_seed  synchronous seed load; overrides all other inputs
//   i_corrupt_period    clean words between bursts; 0 disables injection
//   i_corrupt_len       burst length in words; 0 behaves as 1
//   o_lfsr              emitted word (registered)
//   o_valid             o_lfsr carries a new word this cycle
//   o_err               current word is deliberately corrupted
//   o_word_count        words emitted since reset/seed load (wrapping)
module lfsr_generator
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED,
  parameter logic [LFSR_W-1:0] ERR_MASK = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_load_seed,
  input  logic [LFSR_W-1:0]     i_seed,
  input  logic [CLEAN_W-1:0]    i_corrupt_period,
  input  logic [BURST_W-1:0]    i_corrupt_len,
  output logic [LFSR_W-1:0]     o_lfsr,
  output logic                  o_valid,
  output logic                  o_err,
  output logic [WORD_CNT_W-1:0] o_word_count
);

  lfsr_state_e           r_fsm, w_fsm_nxt;
  logic [LFSR_W-1:0]     r_x, w_x_nxt;
  logic [CLEAN_W-1:0]    r_clean, w_clean_nxt;
  logic [BURST_W-1:0]    r_burst_cnt, w_burst_cnt_nxt;
  logic [BURST_W-1:0]    r_burst_len, w_burst_len_nxt;
  logic [LFSR_W-1:0]     r_out, w_out_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_err, w_err_nxt;
  logic [WORD_CNT_W-1:0] r_word_cnt, w_word_cnt_nxt;

  logic [LFSR_W-1:0]     w_step;
  logic [CLEAN_W-1:0]    w_clean_inc;
  logic [BURST_W-1:0]    w_burst_inc;

  lfsr_step u_step (
    .i_state  (r_x),
    .o_next_c (w_step)
  );

  // Clean counter saturates so that a long run with injection disabled
  // triggers a burst promptly once a period is programmed.
  assign w_clean_inc = (r_clean == {CLEAN_W{1'b1}}) ? r_clean
                                                    : CLEAN_W'(r_clean + CLEAN_W'(1));
  assign w_burst_inc = BURST_W'(r_burst_cnt + BURST_W'(1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm       <= ST_IDLE;
      r_x         <= SEED;
      r_clean     <= '0;
      r_burst_cnt <= '0;
      r_burst_len <= BURST_W'(1);
      r_out       <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_x         <= w_x_nxt;
      r_clean     <= w_clean_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_burst_len <= w_burst_len_nxt;
      r_out       <= w_out_nxt;
      r_valid     <= w_valid_nxt;
      r_err       <= w_err_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_x_nxt         = r_x;
    w_clean_nxt     = r_clean;
    w_burst_cnt_nxt = r_burst_cnt;
    w_burst_len_nxt = r_burst_len;
    w_out_nxt       = r_out;
    w_valid_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_word_cnt_nxt  = r_word_cnt;

    if (i_load_seed) begin
      w_fsm_nxt       = ST_IDLE;
      w_x_nxt         = i_seed;
      w_clean_nxt     = '0;
      w_burst_cnt_nxt = '0;
      w_word_cnt_nxt  = '0;
    end else if (i_enable) begin
      w_x_nxt        = w_step;
      w_valid_nxt    = 1'b1;
      w_word_cnt_nxt = WORD_CNT_W'(r_word_cnt + WORD_CNT_W'(1));
      case (r_fsm)
        ST_IDLE, ST_RUN: begin
          w_out_nxt   = r_x;
          w_clean_nxt = w_clean_inc;
          w_fsm_nxt   = ST_RUN;
          // The word that completes the clean run decides the burst; its
          // length is latched here so later changes cannot shorten it.
          if ((i_corrupt_period != '0) && (w_clean_inc >= i_corrupt_period)) begin
            w_fsm_nxt       = ST_INJECT;
            w_clean_nxt     = '0;
            w_burst_cnt_nxt = '0;
            w_burst_len_nxt = (i_corrupt_len == '0) ? BURST_W'(1) : i_corrupt_len;
          end
        end
        ST_INJECT: begin
          w_out_nxt = r_x ^ ERR_MASK;
          w_err_nxt = 1'b1;
          if (w_burst_inc >= r_burst_len) begin
            w_fsm_nxt       = ST_RUN;
            w_burst_cnt_nxt = '0;
          end else begin
            w_burst_cnt_nxt = w_burst_inc;
          end
        end
        default: begin
          w_fsm_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_lfsr       = r_out;
  assign o_valid      = r_valid;
  assign o_err        = r_err;
  assign o_word_count = r_word_cnt;

endmodule

// File: tb/tb_lfsr_generator.sv
// tb_lfsr_generator: directed scenarios plus randomized traffic, checked
// against a behavioural model of the word stream and burst schedule.
module tb_lfsr_generator;

  localparam logic [7:0] SEED = 8'h01;
  localparam logic [7:0] MASK = 8'h01;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic        i_load_seed;
  logic [7:0]  i_seed;
  logic [7:0]  i_corrupt_period;
  logic [2:0]  i_corrupt_len;
  logic [7:0]  o_lfsr;
  logic        o_valid;
  logic        o_err;
  logic [15:0] o_word_count;

  always #5 clk = ~clk;

  lfsr_generator #(.SEED(SEED), .ERR_MASK(MASK)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_enable         (i_enable),
    .i_load_seed      (i_load_seed),
    .i_seed           (i_seed),
    .i_corrupt_period (i_corrupt_period),
    .i_corrupt_len    (i_corrupt_len),
    .o_lfsr           (o_lfsr),
    .o_valid          (o_valid),
    .o_err            (o_err),
    .o_word_count     (o_word_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: true sequence position, clean words remaining before
  // the next burst, corrupted words left in the current burst.
  logic [7:0] m_x, m_out;
  int         m_clean, m_left, m_count;
  bit         m_valid, m_err;

  function automatic logic [7:0] ref_next(input logic [7:0] x);
    int v;
    bit fb;
    fb = (x >= 8'd128) != ((x % 128) == 0);
    v  = (int'(x) * 2) % 256;
    if (fb) v = v ^ 'h8D;
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_x = SEED; m_out = 8'h00; m_clean = 0; m_left = 0;
    m_count = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_edge();
    m_valid = 0;
    m_err   = 0;
    if (i_load_seed) begin
      m_x = i_seed; m_clean = 0; m_left = 0; m_count = 0;
    end else if (i_enable) begin
      m_valid = 1;
      if (m_left > 0) begin
        m_out = m_x ^ MASK;
        m_err = 1;
        m_left--;
      end else begin
        m_out = m_x;
        m_clean = (m_clean < 255) ? m_clean + 1 : 255;
        if (i_corrupt_period != 0 && m_clean >= int'(i_corrupt_period)) begin
          m_left  = (i_corrupt_len == 0) ? 1 : int'(i_corrupt_len);
          m_clean = 0;
        end
      end
      m_x     = ref_next(m_x);
      m_count = (m_count + 1) % 65536;
    end
  endtask

  task automatic compare_model(input string tag);
    check_eq({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
    check_eq({tag, ".err"},   32'(o_err),   32'(m_err));
    check_eq({tag, ".lfsr"},  32'(o_lfsr),  32'(m_out));
    check_eq({tag, ".count"}, 32'(o_word_count), 32'(m_count));
  endtask

  task automatic step(input bit en, input bit load, input logic [7:0] seed,
                      input logic [7:0] period, input logic [2:0] len, input string tag);
    i_enable = en; i_load_seed = load; i_seed = seed;
    i_corrupt_period = period; i_corrupt_len = len;
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  // Async reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_eq({tag, ".rst_lfsr"},  32'(o_lfsr), 32'h0);
    check_eq({tag, ".rst_valid"}, 32'(o_valid), 32'h0);
    check_eq({tag, ".rst_err"},   32'(o_err), 32'h0);
    check_eq({tag, ".rst_count"}, 32'(o_word_count), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] seq031 [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h00, 8'h8D};
  logic [7:0] seq033 [7]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h21, 8'h40};
  logic       err033 [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] seq035 [3]  = '{8'h80, 8'h00, 8'h8D};

  initial begin
    logic [7:0] period;
    reset = 1'b1; i_enable = 0; i_load_seed = 0; i_seed = 0;
    i_corrupt_period = 0; i_corrupt_len = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.lfsr",  32'(o_lfsr), 32'h0);
    check_eq("reset.valid", 32'(o_valid), 32'h0);
    check_eq("reset.err",   32'(o_err), 32'h0);
    check_eq("reset.count", 32'(o_word_count), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Basic sequence from SEED, injection disabled.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, "seq");
      check_eq("seq.const", 32'(o_lfsr), 32'(seq031[i]));
    end

    // Full period: word 257 repeats word 1.
    for (int i = 10; i < 256; i++) step(1, 0, 0, 0, 0, "period");
    check_eq("period.count256", 32'(o_word_count), 32'd256);
    step(1, 0, 0, 0, 0, "period");
    check_eq("period.word257", 32'(o_lfsr), 32'h01);

    // Burst injection: period 4, length 2.
    step(0, 1, 8'h01, 0, 0, "load");
    check_eq("load.valid", 32'(o_valid), 32'h0);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, 8'd4, 3'd2, "inject");
      check_eq("inject.const", 32'(o_lfsr), 32'(seq033[i]));
      check_eq("inject.err",   32'(o_err),  32'(err033[i]));
    end

    // Enable gap: no valid, nothing skipped.
    step(1, 0, 0, 0, 0, "gap");
    check_eq("gap.before", 32'(o_lfsr), 32'h80);
    step(0, 0, 0, 0, 0, "gap");
    check_eq("gap.valid", 32'(o_valid), 32'h0);
    step(0, 0, 0, 0, 0, "gap");
    step(1, 0, 0, 0, 0, "gap");
    check_eq("gap.after", 32'(o_lfsr), 32'h00);

    // Seed load aborts a burst in progress.
    step(0, 1, 8'h01, 0, 0, "abort");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'd4, 3'd3, "abort");
    check_eq("abort.burst_err", 32'(o_err), 32'h1);
    step(1, 1, 8'h80, 8'd4, 3'd3, "abort");
    check_eq("abort.load_valid", 32'(o_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 8'd4, 3'd3, "abort");
      check_eq("abort.const", 32'(o_lfsr), 32'(seq035[i]));
      check_eq("abort.err",   32'(o_err), 32'h0);
    end
    check_eq("abort.count", 32'(o_word_count), 32'd3);

    // Async reset mid-burst, then restart from SEED.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'd2, 3'd4, "midrst");
    async_reset("midrst");
    step(1, 0, 0, 0, 0, "restart");
    check_eq("restart.seed", 32'(o_lfsr), 32'(SEED));
    check_eq("restart.err",  32'(o_err), 32'h0);

    // Randomized traffic.
    period = 8'd3;
    for (int i = 0; i < 3000; i++) begin
      bit         en, ld;
      logic [7:0] sd;
      logic [2:0] ln;
      if ($urandom_range(0, 31) == 0) period = 8'($urandom_range(0, 8));
      en = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 59) == 0);
      sd = 8'($urandom_range(0, 255));
      ln = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) async_reset("rand");
      else step(en, ld, sd, period, ln, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
